continuous_motor_control_n: RTL and testbench
=============================================

Name: continuous_motor_control_n

Overview:
- Parametrised successor to the fixed 3-way continuous motor command pulser.
- Converts a level command into periodic reset pulses on one of NUM_CMDS one-hot outputs, which retrigger the per-direction motor controllers.
- Adds features the fixed version lacks: configurable period and pulse width, an immediate pulse on command change, a STOP dead-time on direction reversal, and an enable input.
- Sits between the navigation/state logic and the per-direction motor controllers.

Parameters:
- NUM_CMDS, 3, number of command outputs (>=2).
- CMD_W, 2, command width; must be >= clog2(NUM_CMDS).
- PERIOD_CLKS, 4194304, clocks between pulse starts (about 83.9 ms at 50 MHz).
- PULSE_CLKS, 1, pulse width in clocks; 1 <= PULSE_CLKS < PERIOD_CLKS.
- DEADTIME_CLKS, 50000, total STOP hold on reversal; DEADTIME_CLKS >= PULSE_CLKS.
- STOP_CMD, 2, command index meaning stop; must be < NUM_CMDS.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  0 = all outputs quiet.
- cmd  in  CMD_W  requested command, level.
- pulse_out  out  NUM_CMDS  one-hot-or-zero reset pulses to the controllers.
- active_cmd  out  CMD_W  command currently being pulsed.
- busy  out  1  high while in DEADTIME.

Behaviour:
- All outputs are registered.
- Reset (rst high at an edge) forces: state=IDLE, pulse_out=0, active_cmd=STOP_CMD, busy=0, cmd_q=STOP_CMD, period counter=0, dead counter=0.
- rst mid-pulse or mid-deadtime aborts immediately; the next cycle shows reset values.
- cmd is registered into cmd_q every edge. All decisions use cmd_q.
- Valid command: cmd_q < NUM_CMDS. An invalid command is tracked in active_cmd, but no pulse_out bit is ever driven for it.
- Period counter: width clog2(PERIOD_CLKS); counts 0..PERIOD_CLKS-1, then wraps to 0.
- pulse_out[active_cmd] = 1 while state=RUN, the command is valid, and counter < PULSE_CLKS.
- At most one pulse_out bit is high at any time.
- States:
  - IDLE: pulse_out=0, counter held at 0. If enable=1, go to RUN with active_cmd<=cmd_q and counter=0. No dead-time from IDLE.
  - RUN:
    - If enable=0, go to IDLE; pulse_out drops on the next cycle.
    - Else if cmd_q != active_cmd and both are valid, non-STOP commands: reversal. Go to DEADTIME with active_cmd<=STOP_CMD and dead counter=0.
    - Else if cmd_q != active_cmd (any other change): active_cmd<=cmd_q, counter<=0, stay in RUN.
    - Else: counter advances.
  - DEADTIME:
    - busy=1. pulse_out[STOP_CMD]=1 while dead counter < PULSE_CLKS.
    - At dead counter = DEADTIME_CLKS-1: go to RUN with active_cmd<=cmd_q (value sampled at expiry) and counter=0.
    - Commands that change during DEADTIME are ignored until expiry.
    - enable=0 aborts to IDLE.
- Latency: if cmd changes before edge k (cmd_q updated at k), pulse_out for the new command is high from edge k+2 for PULSE_CLKS cycles. After that, pulses start every PERIOD_CLKS cycles.
- Priority when events coincide: rst > enable=0 > reversal > plain change > counting.
- A command change during an active pulse truncates that pulse. Exception: a plain change to the same output index cannot occur, since that is not a change.

Test Plan:
(Params unless stated: NUM_CMDS=3, PERIOD_CLKS=16, PULSE_CLKS=2, DEADTIME_CLKS=6, STOP_CMD=2.)
- Reset and steady state: rst high 3 cycles, then enable=1, cmd=0 → pulse_out=3'b001 for 2 cycles, low 14 cycles, repeating; active_cmd=0; busy=0.
- Reversal: in RUN with cmd=0, switch to cmd=1 → 2 cycles later pulse_out=3'b100 for 2 cycles and busy=1 for 6 cycles; next cycle pulse_out=3'b010 for 2 cycles, then 16-cycle period.
- Change to stop: cmd 0→2 → pulse_out=3'b100 at k+2 immediately; no busy; periodic thereafter.
- Enable gating: enable=0 mid-pulse → pulse_out=0 next cycle and stays 0; enable=1 → fresh pulse 2 cycles later.
- Invalid command: cmd=3 → pulse_out stays 0 indefinitely, active_cmd=3; then cmd=0 → pulse 3'b001 at k+2, with no dead-time.
- Reset mid-deadtime: rst during busy=1 → next cycle busy=0, pulse_out=0, active_cmd=2. Also assert pulse_out is one-hot-or-zero throughout all tests.

Source files
------------

// File: rtl/continuous_motor_control_n.sv
// Periodic one-hot retrigger pulser for the per-direction motor controllers.
// Adds an immediate pulse on command change, a STOP dead-time on reversal, and an enable gate.
module continuous_motor_control_n #(
  parameter int NUM_CMDS      = 3,
  parameter int CMD_W         = 2,
  parameter int PERIOD_CLKS   = 4194304,
  parameter int PULSE_CLKS    = 1,
  parameter int DEADTIME_CLKS = 50000,
  parameter int STOP_CMD      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CMD_W-1:0]    cmd,
  output logic [NUM_CMDS-1:0] pulse_out,
  output logic [CMD_W-1:0]    active_cmd,
  output logic                busy
);

  localparam int CNT_W  = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam int DEAD_W = $clog2(DEADTIME_CLKS + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PERIOD_CLKS - 1);
  localparam logic [CNT_W-1:0]  PULSE_CNT = CNT_W'(PULSE_CLKS);
  localparam logic [DEAD_W-1:0] LAST_DEAD = DEAD_W'(DEADTIME_CLKS - 1);
  localparam logic [DEAD_W-1:0] PULSE_DEAD = DEAD_W'(PULSE_CLKS);
  localparam logic [CMD_W-1:0]  STOP      = CMD_W'(STOP_CMD);
  localparam logic [CMD_W:0]    NUM_C     = (CMD_W+1)'(NUM_CMDS);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] DEADTIME = 2'd2;

  logic [1:0]        state;
  logic [CMD_W-1:0]  cmd_q;
  logic [CNT_W-1:0]  period_cnt;
  logic [DEAD_W-1:0] dead_cnt;

  logic cmd_valid;
  logic active_valid;
  logic changed;
  logic reversal;

  assign cmd_valid    = ({1'b0, cmd_q} < NUM_C);
  assign active_valid = ({1'b0, active_cmd} < NUM_C);
  assign changed      = (cmd_q != active_cmd);
  assign reversal     = changed && cmd_valid && active_valid &&
                        (cmd_q != STOP) && (active_cmd != STOP);

  function automatic logic [NUM_CMDS-1:0] onehot(input logic [CMD_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_CMDS; i++)
      if (idx == CMD_W'(i)) onehot[i] = 1'b1;
  endfunction

  // Outputs are computed from the current counters, so a pulse lags the state update by one
  // clock; any event that leaves the current pulse (abort, change) leaves pulse_out at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pulse_out  <= '0;
      active_cmd <= STOP;
      busy       <= 1'b0;
      cmd_q      <= STOP;
      period_cnt <= '0;
      dead_cnt   <= '0;
    end else begin
      cmd_q     <= cmd;
      pulse_out <= '0;
      busy      <= 1'b0;
      case (state)
        IDLE: begin
          period_cnt <= '0;
          if (enable) begin
            state      <= RUN;
            active_cmd <= cmd_q;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (reversal) begin
            state      <= DEADTIME;
            active_cmd <= STOP;
            dead_cnt   <= '0;
          end else if (changed) begin
            active_cmd <= cmd_q;
            period_cnt <= '0;
          end else begin
            if (active_valid && (period_cnt < PULSE_CNT))
              pulse_out <= onehot(active_cmd);
            period_cnt <= (period_cnt == LAST_CNT) ? '0 : period_cnt + 1'b1;
          end
        end
        DEADTIME: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            busy <= 1'b1;
            if (dead_cnt < PULSE_DEAD)
              pulse_out <= onehot(STOP);
            if (dead_cnt == LAST_DEAD) begin
              state      <= RUN;
              active_cmd <= cmd_q;
              period_cnt <= '0;
            end else begin
              dead_cnt <= dead_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_continuous_motor_control_n.sv
// Directed bench for continuous_motor_control_n with PERIOD=16, PULSE=2, DEADTIME=6, STOP=2.
module tb_continuous_motor_control_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] cmd;
  logic [2:0] pulse_out;
  logic [1:0] active_cmd;
  logic       busy;

  int   vectors = 0;
  int   miscompares = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  continuous_motor_control_n #(
    .NUM_CMDS(3), .CMD_W(2), .PERIOD_CLKS(16), .PULSE_CLKS(2),
    .DEADTIME_CLKS(6), .STOP_CMD(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd(cmd),
    .pulse_out(pulse_out), .active_cmd(active_cmd), .busy(busy)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] p, input logic [1:0] a, input logic b);
    check_output({tag, ".pulse"}, 32'(pulse_out), 32'(p));
    check_output({tag, ".active"}, 32'(active_cmd), 32'(a));
    check_output({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic [1:0] c);
    rst    = r;
    enable = e;
    cmd    = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one controller may be retriggered at a time
  always @(negedge clk)
    if (mon_on) check_output("onehot0", 32'($onehot0(pulse_out)), 32'd1);

  initial begin
    apply_stimulus(1'b1, 1'b0, 2'd0);
    repeat (3) tick();
    expect_all("reset", 3'b000, 2'd2, 1'b0);
    mon_on = 1'b1;

    // Start: IDLE picks up the reset cmd_q (STOP), then a plain change to 0
    apply_stimulus(1'b0, 1'b1, 2'd0);
    tick(); expect_all("start1", 3'b000, 2'd2, 1'b0);
    tick(); expect_all("start2", 3'b000, 2'd0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      tick();
      check_output($sformatf("steady%0d", c), 32'(pulse_out), ((c % 16) < 2) ? 32'h1 : 32'h0);
      check_output($sformatf("steady_busy%0d", c), 32'(busy), 32'h0);
    end

    // Reversal 0 -> 1: old pulse truncated, STOP dead-time, then new direction
    apply_stimulus(1'b0, 1'b1, 2'd1);
    tick(); expect_all("rev_k",   3'b001, 2'd0, 1'b0);
    tick(); expect_all("rev_k1",  3'b000, 2'd2, 1'b0);
    tick(); expect_all("rev_d0",  3'b100, 2'd2, 1'b1);
    tick(); expect_all("rev_d1",  3'b100, 2'd2, 1'b1);
    tick(); expect_all("rev_d2",  3'b000, 2'd2, 1'b1);
    tick(); expect_all("rev_d3",  3'b000, 2'd2, 1'b1);
    tick(); expect_all("rev_d4",  3'b000, 2'd2, 1'b1);
    tick(); expect_all("rev_d5",  3'b000, 2'd1, 1'b1);
    tick(); expect_all("rev_new0", 3'b010, 2'd1, 1'b0);
    tick(); expect_all("rev_new1", 3'b010, 2'd1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      tick();
      check_output($sformatf("rev_gap%0d", c), 32'(pulse_out), 32'h0);
    end
    tick(); expect_all("rev_per0", 3'b010, 2'd1, 1'b0);
    tick(); expect_all("rev_per1", 3'b010, 2'd1, 1'b0);

    // Change 1 -> STOP is a plain change: immediate pulse, no dead-time
    apply_stimulus(1'b0, 1'b1, 2'd2);
    tick(); expect_all("stop_k",  3'b000, 2'd1, 1'b0);
    tick(); expect_all("stop_k1", 3'b000, 2'd2, 1'b0);
    for (int i = 0; i < 18; i++) begin
      tick();
      check_output($sformatf("stop%0d", i), 32'(pulse_out), ((i % 16) < 2) ? 32'h4 : 32'h0);
      check_output($sformatf("stop_busy%0d", i), 32'(busy), 32'h0);
    end
    repeat (14) tick();
    tick(); expect_all("en_prepulse", 3'b100, 2'd2, 1'b0);

    // Enable drop mid-pulse, then re-enable
    apply_stimulus(1'b0, 1'b0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_all($sformatf("en_off%0d", i), 3'b000, 2'd2, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 2'd2);
    tick(); expect_all("en_on0", 3'b000, 2'd2, 1'b0);
    tick(); expect_all("en_on1", 3'b100, 2'd2, 1'b0);
    tick(); expect_all("en_on2", 3'b100, 2'd2, 1'b0);
    tick(); expect_all("en_on3", 3'b000, 2'd2, 1'b0);

    // Invalid command 3: tracked but never pulsed
    apply_stimulus(1'b0, 1'b1, 2'd3);
    tick(); expect_all("inv_k", 3'b000, 2'd2, 1'b0);
    for (int i = 0; i < 25; i++) begin
      tick();
      expect_all($sformatf("inv%0d", i), 3'b000, 2'd3, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 2'd0);
    tick(); expect_all("inv_back_k",  3'b000, 2'd3, 1'b0);
    tick(); expect_all("inv_back_k1", 3'b000, 2'd0, 1'b0);
    tick(); expect_all("inv_back_p0", 3'b001, 2'd0, 1'b0);
    tick(); expect_all("inv_back_p1", 3'b001, 2'd0, 1'b0);
    tick(); expect_all("inv_back_p2", 3'b000, 2'd0, 1'b0);

    // Reset during dead-time
    apply_stimulus(1'b0, 1'b1, 2'd1);
    tick(); expect_all("rst_rev_k",  3'b000, 2'd0, 1'b0);
    tick(); expect_all("rst_rev_k1", 3'b000, 2'd2, 1'b0);
    tick(); expect_all("rst_rev_d0", 3'b100, 2'd2, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'd1);
    tick(); expect_all("rst_mid_dead", 3'b000, 2'd2, 1'b0);
    tick(); expect_all("rst_held",     3'b000, 2'd2, 1'b0);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
